// File: rtl/arbiter4_rr.sv
// Four-requester round-robin arbiter with a hold limit. Grants one requester at a
// time through registered one-hot/encoded outputs and enforces a one-cycle dead gap.
module arbiter4_rr #(
    parameter int HOLD_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_v,
    output logic       timeout,
    output logic [1:0] dbg_state_o
);

    // Handshake: a requester raises req[i] and keeps it high while it wants the
    // resource; gnt[i] rises one edge after req is seen in IDLE and stays up until
    // done, req[i] falling, or the hold limit; done is only looked at while granted.

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX);

    state_e        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    own_q, own_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    gnt_idx_q, gnt_idx_d;
    logic          gnt_v_q, gnt_v_d;
    logic          timeout_q, timeout_d;

    logic [1:0]    win;
    logic          req_any;

    // Rotating priority scan starting at ptr_q.
    always_comb begin
        logic [1:0] idx;
        logic       found;
        win     = ptr_q;
        req_any = |req;
        found   = 1'b0;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        own_d     = own_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_v_d   = gnt_v_q;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d   = ST_BUSY;
                    own_d     = win;
                    gnt_d     = 4'b0001 << win;
                    gnt_idx_d = win;
                    gnt_v_d   = 1'b1;
                    cnt_d     = CW'(1);
                end
            end
            ST_BUSY: begin
                if (done || !req[own_q] || (cnt_q == HOLD_LIM)) begin
                    state_d   = ST_GAP;
                    // Only a release not explained by done or a dropped request is forced.
                    timeout_d = !done && req[own_q];
                    gnt_d     = 4'b0000;
                    gnt_idx_d = 2'd0;
                    gnt_v_d   = 1'b0;
                    cnt_d     = '0;
                    ptr_d     = own_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            cnt_q     <= '0;
            own_q     <= 2'd0;
            gnt_q     <= 4'b0000;
            gnt_idx_q <= 2'd0;
            gnt_v_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            own_q     <= own_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_v_q   <= gnt_v_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt         = gnt_q;
    assign gnt_idx     = gnt_idx_q;
    assign gnt_v       = gnt_v_q;
    assign timeout     = timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_arbiter4_rr.sv
// Self-checking bench for arbiter4_rr: directed scenarios plus random traffic,
// all compared against a cycle-level behavioural model of the arbitration rules.
module tb_arbiter4_rr;

    localparam int HOLD_MAX = 15;
    localparam int CW       = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_v;
    logic       timeout;
    logic [1:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Model: owner is -1 when nothing is granted.
    int m_owner;
    int m_held;
    int m_gap;
    int m_next;
    int m_to;

    logic [7:0] exp_q[$];
    logic       prev_v;
    int         to_cnt;

    arbiter4_rr #(.HOLD_MAX(HOLD_MAX), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .gnt_v      (gnt_v),
        .timeout    (timeout),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_gap   = 0;
        m_next  = 0;
        m_to    = 0;
        prev_v  = 1'b0;
        to_cnt  = 0;
        exp_q.delete();
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [7:0] e_gnt, e_idx, e_v;
        e_gnt = (m_owner >= 0) ? 8'(1 << m_owner) : 8'd0;
        e_idx = (m_owner >= 0) ? 8'(m_owner) : 8'd0;
        e_v   = (m_owner >= 0) ? 8'd1 : 8'd0;
        check("gnt", {4'd0, gnt}, e_gnt);
        check("gnt_idx", {6'd0, gnt_idx}, e_idx);
        check("gnt_v", {7'd0, gnt_v}, e_v);
        check("timeout", {7'd0, timeout}, 8'(m_to));
        if (gnt_v && !prev_v && exp_q.size() > 0)
            check("grant_order", {6'd0, gnt_idx}, exp_q.pop_front());
        if (timeout) to_cnt++;
        prev_v = gnt_v;
    endtask

    // One clock edge applied to the model with the inputs currently driven.
    task automatic model_edge();
        m_to = 0;
        if (m_owner >= 0) begin
            if (done || !req[m_owner] || m_held == HOLD_MAX) begin
                m_to    = (!done && req[m_owner]) ? 1 : 0;
                m_next  = (m_owner + 1) % 4;
                m_owner = -1;
                m_held  = 0;
                m_gap   = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap != 0) begin
            m_gap = 0;
        end else if (req != 4'd0) begin
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_next + k) % 4]) m_owner = (m_next + k) % 4;
            end
            m_held = 1;
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drive inputs, take one edge, compare at the next negedge.
    task automatic cyc(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        req   = 4'd0;
        done  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        compare_all();
        rst_n = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        check(tag, 8'(exp_q.size()), 8'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req   = 4'd0;
        done  = 1'b0;
        model_reset();
        @(negedge clk);
        check("reset_state", {6'd0, dbg_state}, 8'd0);
        do_reset();

        // Alternating pair with done one cycle into each grant.
        exp_q = '{8'd0, 8'd2, 8'd0, 8'd2};
        for (int i = 0; i < 13; i++) cyc(4'b0101, (m_owner >= 0) ? 1'b1 : 1'b0);
        check_drained("pair_order_done");

        // All requesting, done on the third busy cycle.
        do_reset();
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        for (int i = 0; i < 26; i++) cyc(4'b1111, (m_owner >= 0 && m_held == 3) ? 1'b1 : 1'b0);
        check_drained("all_order_done");

        // Lone requester never finishing: forced release at the hold limit.
        do_reset();
        exp_q = '{8'd1, 8'd1};
        for (int i = 0; i < 20; i++) cyc(4'b0010, 1'b0);
        check_drained("hold_limit_regrant");
        check("hold_limit_pulses", 8'(to_cnt), 8'd1);

        // Owner 3 abandons while requester 0 waits.
        do_reset();
        exp_q = '{8'd3, 8'd0};
        for (int i = 0; i < 3; i++) cyc(4'b1000, 1'b0);
        for (int i = 0; i < 5; i++) cyc(4'b0001, 1'b0);
        check_drained("abandon_order");
        check("abandon_no_timeout", 8'(to_cnt), 8'd0);

        // done coincides with reaching the hold limit.
        do_reset();
        exp_q = '{8'd1, 8'd2};
        for (int i = 0; i < 20; i++) cyc(4'b0110, (m_owner >= 0 && m_held == HOLD_MAX) ? 1'b1 : 1'b0);
        check_drained("done_at_limit_order");
        check("done_at_limit_no_timeout", 8'(to_cnt), 8'd0);

        // Asynchronous reset in the middle of a grant to requester 2.
        do_reset();
        exp_q = '{8'd0, 8'd2};
        cyc(4'b0001, 1'b0);
        cyc(4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) cyc(4'b0100, 1'b0);
        check("pre_reset_gnt", {4'd0, gnt}, 8'h04);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_gnt", {4'd0, gnt}, 8'd0);
        check("async_rst_gnt_v", {7'd0, gnt_v}, 8'd0);
        check("async_rst_gnt_idx", {6'd0, gnt_idx}, 8'd0);
        check("async_rst_timeout", {7'd0, timeout}, 8'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        exp_q = '{8'd0};
        for (int i = 0; i < 3; i++) cyc(4'b0101, 1'b0);
        check_drained("post_reset_order");

        // Random traffic with sticky requests.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            r = req;
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            cyc(r, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
